// File: rtl/rr_port_arbiter.sv
// Round-robin crossbar output arbiter: grants one eligible input buffer for a
// whole packet and counts completed four-phase words before rotating priority.
module rr_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                         Clock,
    input  logic                         nReset,
    input  logic [NUM_IN-1:0]            Req,
    input  logic [NUM_IN-1:0]            Busy_Elsewhere,
    input  logic [NUM_IN*LEN_WIDTH-1:0]  Len,
    input  logic [NUM_IN-1:0]            Ch_M_Req,
    input  logic [NUM_IN*DATA_WIDTH-1:0] Ch_Data,
    output logic [NUM_IN-1:0]            Ch_Ack,
    output logic                         M_Req,
    output logic [DATA_WIDTH-1:0]        M_Data,
    input  logic                         M_Ack,
    output logic [NUM_IN-1:0]            Grant,
    output logic                         Active
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [1:0] {IDLE, XFER, CLOSE} state_t;

    state_t               state, state_nxt;
    logic [NUM_IN-1:0]    grant_q, grant_nxt;
    logic [PTR_W-1:0]     ptr_q, ptr_nxt;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_nxt;
    logic [LEN_WIDTH-1:0] plen_q, plen_nxt;
    logic                 m_ack_d;

    logic [NUM_IN-1:0]    eligible;
    logic                 found;
    logic [PTR_W-1:0]     scan_idx;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     gidx;
    logic [LEN_WIDTH-1:0] pick_len;
    logic                 ack_rise;

    assign eligible = Req & ~Busy_Elsewhere;
    assign ack_rise = M_Ack & ~m_ack_d;

    // First eligible input scanning from ptr_q upward, wrapping at NUM_IN.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = PTR_W'((int'(ptr_q) + k) % NUM_IN);
            if (!found && eligible[scan_idx]) begin
                found    = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    assign pick_len = Len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) gidx = PTR_W'(i);
        end
    end

    // Datapath is steered purely by the grant register, so reset clears it at once.
    always_comb begin
        M_Data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) M_Data = M_Data | Ch_Data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign M_Req  = |(grant_q & Ch_M_Req);
    assign Ch_Ack = grant_q & {NUM_IN{M_Ack}};
    assign Grant  = grant_q;
    assign Active = |grant_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        plen_nxt  = plen_q;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = {{(NUM_IN-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_nxt   = '0;
                    plen_nxt  = (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (ack_rise) begin
                    cnt_nxt = cnt_q + LEN_WIDTH'(1);
                    if (cnt_q + LEN_WIDTH'(1) == plen_q) state_nxt = CLOSE;
                end
            end
            CLOSE: begin
                // Hold ownership until the last handshake has fully returned to zero.
                if (!M_Ack && !M_Req) begin
                    grant_nxt = '0;
                    ptr_nxt   = (gidx == PTR_W'(NUM_IN-1)) ? '0 : gidx + PTR_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state is reset asynchronously; a mid-packet reset must drop the grant without waiting for a clock.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            plen_q  <= '0;
            m_ack_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
            plen_q  <= plen_nxt;
            m_ack_d <= M_Ack;
        end
    end

endmodule

// File: doc/rr_port_arbiter.md
# rr_port_arbiter

Round-robin output-port arbiter for the mesh router crossbar. One instance sits in front of each crossbar output (XP, XN, YP, YN, PE). It picks one of the competing input buffers already routed to that output and holds the grant for a whole packet by counting completed Req/Ack words. It then passes grant ownership to the next requester in rotating order, replacing fixed priority and preventing starvation.

## Interface
- DATA_WIDTH, 32, word width of channel data
- NUM_IN, 4, number of competing input buffers (the four non-self directions)
- LEN_WIDTH, 8, width of packet length field
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous, active-low reset
- Req  input  NUM_IN  input i holds a head packet routed to this output; held until its packet completes
- Busy_Elsewhere  input  NUM_IN  input i is currently granted by another output arbiter; masks Req[i]
- Len  input  NUM_IN*LEN_WIDTH  packet length in words for input i (slice i); sampled at grant
- Ch_M_Req  input  NUM_IN  per-input word request (four-phase)
- Ch_Data  input  NUM_IN*DATA_WIDTH  per-input word data (slice i)
- Ch_Ack  output  NUM_IN  acknowledge routed back to the granted input only
- M_Req  output  1  word request to downstream link
- M_Data  output  DATA_WIDTH  data to downstream link
- M_Ack  input  1  downstream acknowledge
- Grant  output  NUM_IN  registered one-hot grant; drives other arbiters' Busy_Elsewhere
- Active  output  1  high while any grant is held

## Operation
- States: IDLE, XFER, CLOSE.
- Eligible[i] = Req[i] & ~Busy_Elsewhere[i].
- IDLE:
  - If any input is eligible, grant the first eligible index searching Ptr, Ptr+1, … modulo NUM_IN.
  - Load Cnt = 0 and Plen = Len[granted]. Len 0 is loaded as 1.
  - Go to XFER.
- XFER:
  - Each rising edge of M_Ack (registered M_Ack_d low, M_Ack high) increments Cnt.
  - When that increment makes Cnt == Plen, go to CLOSE.
- CLOSE:
  - Wait until M_Ack == 0 and M_Req == 0 (final handshake fully returned to zero).
  - Then clear Grant, set Ptr = (granted index + 1) mod NUM_IN, and return to IDLE.
  - No new grant is issued in the same cycle.
- Datapath is combinational from the Grant register:
  - M_Req = Ch_M_Req[g] and M_Data = Ch_Data[g] when granted.
  - Otherwise M_Req = 0 and M_Data = 0.
  - Ch_Ack[g] = M_Ack; all other Ch_Ack bits are 0.
- Grant is always zero or one-hot. Req deasserting mid-packet does not release the grant; only the word count does.
- Cnt is LEN_WIDTH bits. The maximum packet is 2^LEN_WIDTH−1 words, so Cnt never wraps.
- Ptr wraps NUM_IN−1 → 0.

## Timing
- Reset values:
  - Grant = 0, Active = 0, M_Req = 0, M_Data = 0, Ch_Ack = 0.
  - State = IDLE, Ptr = 0, Cnt = 0, M_Ack_d = 0.
- Grant latency: Eligible seen on edge n gives Grant/Active high after edge n; M_Req can follow Ch_M_Req in that same cycle.
- Release: the edge after CLOSE sees M_Req = M_Ack = 0 drops Grant. The earliest next grant is one edge later, so there is a minimum one idle cycle between packets.
- Simultaneous eligible requests: the round-robin order from Ptr decides. The just-served input has the lowest priority on the next arbitration.
- Busy_Elsewhere rising on the same edge as arbitration: that input is not granted.
- Reset mid-packet: everything returns to reset values immediately (asynchronously). The partial packet is abandoned, and Ch_Ack drops at once.
- M_Ack held high across multiple cycles counts as one word. An ack seen while in IDLE is ignored.

## Test plan
- Single packet: Req[1]=1, Len[1]=3, three four-phase words with data 0xA1, 0xA2, 0xA3 -> Grant=0010 one cycle after Req; M_Data matches each word; Ch_Ack[1] mirrors M_Ack; Grant drops after the 3rd handshake closes; Ptr=2.
- Round-robin: Req=1111 held, each Len=1 -> grant order 0,1,2,3,0 with one idle cycle between grants; no input granted twice before all others have been served.
- Masking: Req=0011, Busy_Elsewhere=0001 -> Grant=0010. Clearing Busy_Elsewhere during input 1's packet does not change Grant until that packet ends.
- Boundaries:
  - Len=0 -> treated as 1 word.
  - Len=255 -> exactly 255 M_Ack rising edges counted before release.
  - M_Ack held high 5 cycles -> counts as 1.
- Reset mid-packet: nReset low after word 2 of 4 -> Grant, Active, M_Req and Ch_Ack are 0 in the same cycle. After release, a new Req[3] is granted from Ptr=0 ordering.
- Ack isolation: during a grant to input 2, toggle Ch_M_Req[0] and Ch_M_Req[3] -> M_Req follows only Ch_M_Req[2]; Ch_Ack[0], Ch_Ack[1] and Ch_Ack[3] stay 0.
